// File: rtl/vga_scanout.sv
// 320x240x3 frame buffer with a pixel-write port, scanned out as 640x480@60 VGA
// with each stored pixel doubled 2x2. One clk domain; the pixel rate is clk/2.
module vga_scanout #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] x,
  input  logic [7:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  output logic       vga_clk,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned FB_DEPTH = 320 * 240;

  logic        r_pix_en;
  logic        r_vga_clk;
  logic [9:0]  r_h;
  logic [9:0]  r_v;
  logic [9:0]  w_h_next;
  logic [9:0]  w_v_next;
  logic        r_hs;
  logic        r_vs;
  logic        r_blank;
  logic [2:0]  r_rd_data;
  logic [2:0]  r_mem [FB_DEPTH];
  logic        w_active;
  logic        w_hs_raw;
  logic        w_vs_raw;
  logic        w_wr_en;
  logic [16:0] w_rd_addr;
  logic [16:0] w_wr_addr;

  always_comb begin
    w_h_next = r_h + 10'd1;
    w_v_next = r_v;
    if (r_h == 10'(H_TOTAL - 1)) begin
      w_h_next = '0;
      w_v_next = (r_v == 10'(V_TOTAL - 1)) ? '0 : r_v + 10'd1;
    end
  end

  assign w_active = (r_h < 10'(H_ACTIVE)) && (r_v < 10'(V_ACTIVE));
  assign w_hs_raw = !((r_h >= 10'(H_ACTIVE + H_FRONT)) &&
                      (r_h <  10'(H_ACTIVE + H_FRONT + H_SYNC)));
  assign w_vs_raw = !((r_v >= 10'(V_ACTIVE + V_FRONT)) &&
                      (r_v <  10'(V_ACTIVE + V_FRONT + V_SYNC)));

  // row * 320 as row * 256 + row * 64; rows/columns halved for 2x2 doubling
  assign w_rd_addr = 17'({r_v[8:1], 8'b0}) + 17'({r_v[8:1], 6'b0}) + 17'(r_h[9:1]);
  assign w_wr_addr = 17'({y, 8'b0}) + 17'({y, 6'b0}) + 17'(x);
  assign w_wr_en   = plot && !reset && (x < 9'd320) && (y < 8'd240);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pix_en  <= 1'b0;
      r_vga_clk <= 1'b0;
      r_h       <= '0;
      r_v       <= '0;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank   <= 1'b0;
    end else begin
      r_pix_en  <= ~r_pix_en;
      r_vga_clk <= r_pix_en;
      if (r_pix_en) begin
        r_h     <= w_h_next;
        r_v     <= w_v_next;
        r_hs    <= w_hs_raw;
        r_vs    <= w_vs_raw;
        r_blank <= w_active;
      end
    end
  end

  // Not reset: the picture survives a reset. Same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= colour;
    end
    if (r_pix_en) begin
      r_rd_data <= r_mem[w_rd_addr];
    end
  end

  assign vga_clk     = r_vga_clk;
  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign vga_blank_n = r_blank;
  assign vga_sync_n  = 1'b0;
  assign vga_r       = r_blank ? {8{r_rd_data[2]}} : 8'h00;
  assign vga_g       = r_blank ? {8{r_rd_data[1]}} : 8'h00;
  assign vga_b       = r_blank ? {8{r_rd_data[0]}} : 8'h00;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a shrunken-timing instance for whole-frame checks and a
// full 640x480 instance whose first scan line is measured.
module tb_vga_scanout;

  localparam int unsigned HA = 32;
  localparam int unsigned HF = 4;
  localparam int unsigned HS = 6;
  localparam int unsigned HB = 6;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VA = 16;
  localparam int unsigned VF = 2;
  localparam int unsigned VS = 2;
  localparam int unsigned VB = 4;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FR = HT * VT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] x = '0;
  logic [7:0] y = '0;
  logic [2:0] colour = '0;
  logic       plot = 1'b0;

  logic       vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       f_vga_clk, f_vga_hs, f_vga_vs, f_vga_blank_n, f_vga_sync_n;
  logic [7:0] f_vga_r, f_vga_g, f_vga_b;

  typedef struct {
    int unsigned idx;
    logic [27:0] vec;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  int unsigned pix_k = 0;
  bit          epoch = 1'b0;
  bit          f_done = 1'b0;

  always #5 clk = ~clk;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) u_dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .colour(colour), .plot(plot),
    .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_sync_n(vga_sync_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  vga_scanout u_dut_full (
    .clk(clk), .reset(reset), .x(x), .y(y), .colour(colour), .plot(plot),
    .vga_clk(f_vga_clk), .vga_hs(f_vga_hs), .vga_vs(f_vga_vs),
    .vga_blank_n(f_vga_blank_n), .vga_sync_n(f_vga_sync_n),
    .vga_r(f_vga_r), .vga_g(f_vga_g), .vga_b(f_vga_b)
  );

  // Posedges seen with reset low since the last reset.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [27:0] mk(input logic hs, input logic vs, input logic bl,
                                     input logic [2:0] c);
    return {hs, vs, bl, 1'b0, {8{c[2] & bl}}, {8{c[1] & bl}}, {8{c[0] & bl}}};
  endfunction

  function automatic logic [27:0] cur_vec();
    return {vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_r, vga_g, vga_b};
  endfunction

  task automatic check_vec(input string nm, input logic [27:0] act, input logic [27:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {hs,vs,blank_n,sync_n,r,g,b}=%h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Visible pixel (px,py) of frame f; pixel k appears after posedge 2k+2.
  task automatic push_px(input int unsigned f, input int unsigned px, input int unsigned py,
                         input logic [2:0] c, input string nm);
    exp_t e;
    e.idx  = f * FR + py * HT + px;
    e.vec  = mk(1'b1, 1'b1, 1'b1, c);
    e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic push_raw(input int unsigned idx, input logic [27:0] vec, input string nm);
    exp_t e;
    e.idx  = idx;
    e.vec  = vec;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  // Drive a write so that it is sampled on posedge n (counted from reset release).
  task automatic wr_at(input int unsigned n, input int unsigned wx, input int unsigned wy,
                       input logic [2:0] c);
    while (cyc + 1 < n) begin
      @(posedge clk);
      #1;
    end
    plot = 1'b1; x = 9'(wx); y = 8'(wy); colour = c;
    @(posedge clk);
    #1;
    plot = 1'b0;
  endtask

  task automatic drain(input int unsigned limit, input string nm);
    int unsigned i = 0;
    while (sb_q.size() != 0 && i < limit) begin
      @(posedge clk);
      i++;
    end
    check_int(nm, sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin : vclk_mon
    forever begin
      @(negedge clk);
      if (!reset && cyc >= 1 && cyc <= 8) check_int("vga_clk_phase", vga_clk, (cyc % 2 == 0));
    end
  end

  initial begin : monitor
    int unsigned hx, vy, fr;
    int          hs_cnt, hs_first, bl_cnt, vs_cnt, vs_first;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (reset) begin
        pix_k = 0;
        continue;
      end
      if (!vga_clk) continue;
      while (sb_q.size() != 0 && sb_q[0].idx < pix_k) begin
        e = sb_q.pop_front();
        check_int({e.name, "_missed_at_idx"}, pix_k, e.idx);
      end
      if (sb_q.size() != 0 && sb_q[0].idx == pix_k) begin
        e = sb_q.pop_front();
        check_vec(e.name, cur_vec(), e.vec);
      end
      hx = pix_k % HT;
      vy = (pix_k / HT) % VT;
      fr = pix_k / FR;
      if (!epoch && fr == 1) begin
        if (hx == 0) begin hs_cnt = 0; hs_first = -1; bl_cnt = 0; end
        if (hx == 0 && vy == 0) begin vs_cnt = 0; vs_first = -1; end
        if (!vga_hs) begin
          if (hs_cnt == 0) hs_first = int'(hx);
          hs_cnt++;
        end
        if (vga_blank_n) bl_cnt++;
        if (!vga_vs) begin
          if (vs_cnt == 0) vs_first = int'(vy);
          vs_cnt++;
        end
        if (hx == HT - 1) begin
          check_int("hs_low_len", hs_cnt, HS);
          check_int("hs_start", hs_first, HA + HF);
          check_int("blank_n_len", bl_cnt, (vy < VA) ? HA : 0);
        end
        if (pix_k == 2 * FR - 1) begin
          check_int("vs_low_len", vs_cnt, VS * HT);
          check_int("vs_start_line", vs_first, VA + VF);
        end
      end
      pix_k++;
    end
  end

  initial begin : full_mon
    int fk, hs_lo, hs_first, bl, vs_lo, guard;
    fk = 0; hs_lo = 0; hs_first = -1; bl = 0; vs_lo = 0; guard = 0;
    wait (!reset);
    while (fk < 800 && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (f_vga_clk) begin
        if (!f_vga_hs) begin
          if (hs_lo == 0) hs_first = fk;
          hs_lo++;
        end
        if (f_vga_blank_n) bl++;
        if (!f_vga_vs) vs_lo++;
        fk++;
      end
    end
    check_int("full_line_pixels", fk, 800);
    check_int("full_hs_low_len", hs_lo, 96);
    check_int("full_hs_start", hs_first, 656);
    check_int("full_blank_n_len", bl, 640);
    check_int("full_vs_low_line0", vs_lo, 0);
    f_done = 1'b1;
  end

  initial begin : stimulus
    int unsigned guard;
    // A write during reset must be ignored: it would light screen (2,0).
    plot = 1'b1; x = 9'd1; y = 8'd0; colour = 3'b111;
    repeat (4) begin
      @(negedge clk);
      check_vec("reset_outputs", cur_vec(), mk(1'b1, 1'b1, 1'b0, 3'b000));
      check_int("reset_vga_clk", vga_clk, 0);
    end
    @(posedge clk);
    #1;
    plot = 1'b0;

    push_px(0, 0, 0, 3'b100, "f0_px_0_0");
    push_px(0, 1, 0, 3'b100, "f0_px_1_0");
    push_px(0, 2, 0, 3'b000, "f0_px_2_0");
    push_raw(40, mk(1'b0, 1'b1, 1'b0, 3'b111), "f0_hblank_rgb_forced_0");
    push_px(0, 0, 1, 3'b100, "f0_px_0_1");
    push_px(0, 1, 1, 3'b100, "f0_px_1_1");
    push_px(0, 10, 10, 3'b001, "f0_px_10_10");
    push_px(0, 0, 12, 3'b000, "f0_oob_x_dropped_0_12");
    push_px(0, 1, 13, 3'b000, "f0_oob_x_dropped_1_13");
    push_px(0, 30, 14, 3'b011, "f0_corner_30_14");
    push_px(0, 31, 15, 3'b011, "f0_corner_31_15");
    push_px(1, 10, 10, 3'b001, "f1_collision_old");
    push_px(1, 11, 10, 3'b010, "f1_after_collision");
    push_px(1, 30, 14, 3'b011, "f1_corner_30_14");
    push_px(2, 10, 10, 3'b010, "f2_collision_new");
    push_px(2, 11, 11, 3'b010, "f2_px_11_11");

    reset = 1'b0;
    wr_at(1, 0, 0, 3'b100);
    wr_at(3, 320, 5, 3'b111);
    wr_at(4, 10, 240, 3'b111);
    wr_at(5, 15, 7, 3'b011);
    wr_at(6, 5, 5, 3'b001);
    wr_at(7, 20, 0, 3'b111);
    // Lands on the very edge that reads screen (10,10) of frame 1.
    wr_at(2 * (FR + 10 * HT + 10) + 2, 5, 5, 3'b010);
    drain(20000, "pending_before_mid_reset");

    while (cyc < 2 * (3 * FR + 8 * HT) + 2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    epoch = 1'b1;
    push_px(0, 0, 0, 3'b100, "rst_px_0_0");
    push_px(0, 2, 0, 3'b000, "rst_px_2_0");
    push_px(0, 10, 10, 3'b010, "rst_px_10_10");
    push_px(0, 0, 12, 3'b000, "rst_px_0_12");
    push_px(0, 30, 14, 3'b011, "rst_px_30_14");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    drain(10000, "pending_after_mid_reset");

    guard = 0;
    while (!f_done && guard < 10000) begin
      @(posedge clk);
      guard++;
    end
    check_int("full_monitor_done", f_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
